tmds_channel_encoder: RTL and testbench

// - DVI 1.0 / HDMI TMDS 8b/10b encoder for one colour channel; one instance each for R, G, B.
// - Input: 8-bit pixel data, 2-bit control (blue channel carries {vsync,hsync}), video-enable.
// - Output: 10-bit symbol for the downstream 10:1 serializer.
// - Video period: DC-balanced, transition-minimised data symbol. Blanking: one of four control tokens.

---
 rtl/tmds_pkg.sv | 23 ++
 rtl/tmds_transition_min.sv | 23 ++
 rtl/tmds_channel_encoder.sv | 88 ++++++++
 tb/tb_tmds_channel_encoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// rtl/tmds_pkg.sv - shared TMDS types, control tokens and popcount helper
package tmds_pkg;

    typedef logic signed [4:0] tmds_disp_t;

    // Indexed by {C1,C0}
    localparam logic [9:0] CTRL_TOKEN [4] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_transition_min.sv
// rtl/tmds_transition_min.sv - TMDS stage 1: transition-minimising XOR/XNOR chain
module tmds_transition_min
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output logic [8:0] q_m
);

    logic [3:0] n1d;
    logic       use_xnor;

    always_comb begin
        n1d      = popcount8(data);
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !data[0]);
        q_m      = 9'd0;
        q_m[0]   = data[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
        end
        q_m[8] = ~use_xnor;
    end

endmodule

// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - TMDS 8b/10b channel encoder: DC balance, control tokens, output register
// Optional macro TMDS_ENC_PIPE_EN adds a pipeline stage before DC balancing (latency 2).
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic [1:0] i_control,
    input  logic       i_ve,
    output logic [9:0] o_tmds
);

    logic [8:0] q_m;
    logic [8:0] s2_qm;
    logic [3:0] s2_n1;
    logic       s2_ve;
    logic [1:0] s2_ctrl;

    tmds_transition_min u_tmin (
        .data (i_data),
        .q_m  (q_m)
    );

`ifdef TMDS_ENC_PIPE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_qm   <= 9'd0;
            s2_n1   <= 4'd0;
            s2_ve   <= 1'b0;
            s2_ctrl <= 2'd0;
        end else begin
            s2_qm   <= q_m;
            s2_n1   <= popcount8(q_m[7:0]);
            s2_ve   <= i_ve;
            s2_ctrl <= i_control;
        end
    end
`else
    assign s2_qm   = q_m;
    assign s2_n1   = popcount8(q_m[7:0]);
    assign s2_ve   = i_ve;
    assign s2_ctrl = i_control;
`endif

    tmds_disp_t cnt;
    tmds_disp_t cnt_next;
    tmds_disp_t diff;
    tmds_disp_t two_q8;
    logic [9:0] sym_next;
    logic       q8;
    logic [7:0] qv;

    // diff = n1 - n0 = 2*n1 - 8; modulo-32 wrap at n1=8 still yields +8
    assign diff   = $signed({s2_n1, 1'b0}) - 5'sd8;
    assign q8     = s2_qm[8];
    assign qv     = s2_qm[7:0];
    assign two_q8 = q8 ? 5'sd2 : 5'sd0;

    always_comb begin
        sym_next = 10'd0;
        cnt_next = cnt;
        if (!s2_ve) begin
            sym_next = CTRL_TOKEN[s2_ctrl];
            cnt_next = 5'sd0;
        end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
            sym_next = {~q8, q8, q8 ? qv : ~qv};
            cnt_next = q8 ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
            sym_next = {1'b1, q8, ~qv};
            cnt_next = cnt + two_q8 - diff;
        end else begin
            sym_next = {1'b0, q8, qv};
            cnt_next = cnt + diff - (q8 ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tmds <= 10'h000;
            cnt    <= 5'sd0;
        end else begin
            o_tmds <= sym_next;
            cnt    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb/tb_tmds_channel_encoder.sv - scoreboard bench for tmds_channel_encoder against a behavioural model
module tb_tmds_channel_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic [1:0] control = 2'd0;
    logic       ve = 1'b0;
    logic [9:0] tmds;

    int checks = 0;
    int errors = 0;

    tmds_channel_encoder dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_control (control),
        .i_ve      (ve),
        .o_tmds    (tmds)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] exp;
        logic       is_data;
        logic [7:0] data;
        logic       has_fixed;
        logic [9:0] fixed;
    } exp_t;

    exp_t exp_q[$];
    logic [9:0] tok [4];
    int m_cnt = 0;

    function automatic logic [9:0] model(input logic r, input logic v, input logic [1:0] c, input logic [7:0] d);
        int n1d, n1, n0;
        bit xn;
        logic [7:0] qv;
        logic q8;
        logic [9:0] o;
        if (r) begin
            m_cnt = 0;
            return 10'h000;
        end
        if (!v) begin
            m_cnt = 0;
            return tok[c];
        end
        n1d = $countones(d);
        xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qv[0] = d[0];
        for (int i = 1; i < 8; i++) qv[i] = xn ? ~(qv[i-1] ^ d[i]) : (qv[i-1] ^ d[i]);
        q8 = !xn;
        n1 = $countones(qv);
        n0 = 8 - n1;
        if (m_cnt == 0 || n1 == n0) begin
            o = {~q8, q8, q8 ? qv : ~qv};
            m_cnt += q8 ? (n1 - n0) : (n0 - n1);
        end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
            o = {1'b1, q8, ~qv};
            m_cnt += 2 * int'(q8) + (n0 - n1);
        end else begin
            o = {1'b0, q8, qv};
            m_cnt += (n1 - n0) - 2 * int'(!q8);
        end
        return o;
    endfunction

    task automatic step(input logic r, input logic v, input logic [1:0] c, input logic [7:0] d,
                        input logic hf, input logic [9:0] fx, output logic [9:0] predicted);
        exp_t e;
        @(negedge clk);
        rst = r;
        ve = v;
        control = c;
        data = d;
        e.exp = model(r, v, c, d);
        e.is_data = !r && v;
        e.data = d;
        e.has_fixed = hf;
        e.fixed = fx;
        predicted = e.exp;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: output at edge k reflects inputs issued just before edge k
    initial begin
        exp_t e;
        int rd;
        logic [7:0] x;
        logic [7:0] dec;
        rd = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("symbol", tmds, e.exp);
                if (e.has_fixed) chk("directed", tmds, e.fixed);
                if (e.is_data) begin
                    x = tmds[9] ? ~tmds[7:0] : tmds[7:0];
                    dec[0] = x[0];
                    for (int i = 1; i < 8; i++) dec[i] = tmds[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
                    chk("decode", {2'b00, dec}, {2'b00, e.data});
                    rd += 2 * $countones(tmds) - 10;
                    checks++;
                    if (rd > 10 || rd < -10) begin
                        errors++;
                        $display("FAIL running_disparity: got %0d, required within +/-10", rd);
                    end
                end else begin
                    rd = 0;
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", exp_q.size());
        $fatal(1);
    end

    initial begin
        logic [9:0] p;
        logic [7:0] seq [16];
        logic [9:0] first_run [16];
        tok[0] = 10'h354;
        tok[1] = 10'h0AB;
        tok[2] = 10'h154;
        tok[3] = 10'h2AB;

        // Reset held three clocks with arbitrary inputs
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'($urandom), 2'($urandom), 8'($urandom), 1'b1, 10'h000, p);

        // Control tokens
        step(1'b0, 1'b0, 2'd0, 8'($urandom), 1'b1, 10'h354, p);
        step(1'b0, 1'b0, 2'd1, 8'($urandom), 1'b1, 10'h0AB, p);
        step(1'b0, 1'b0, 2'd2, 8'($urandom), 1'b1, 10'h154, p);
        step(1'b0, 1'b0, 2'd3, 8'($urandom), 1'b1, 10'h2AB, p);

        // Disparity chain from cnt=0
        step(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 10'h100, p);
        step(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 10'h3FF, p);

        // XNOR path after blanking
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 10'h354, p);
        step(1'b0, 1'b1, 2'd0, 8'hFF, 1'b1, 10'h200, p);

        // Every data value from cnt=0
        for (int v = 0; v < 256; v++) begin
            step(1'b0, 1'b0, 2'($urandom), 8'($urandom), 1'b0, 10'h000, p);
            step(1'b0, 1'b1, 2'd0, 8'(v), 1'b0, 10'h000, p);
        end

        // Long random streams with occasional blanking
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0)
                step(1'b0, 1'b0, 2'($urandom), 8'($urandom), 1'b0, 10'h000, p);
            else
                step(1'b0, 1'b1, 2'($urandom), 8'($urandom), 1'b0, 10'h000, p);
        end

        // Mid-stream reset, then resume
        step(1'b0, 1'b1, 2'd0, 8'h3C, 1'b0, 10'h000, p);
        step(1'b1, 1'b1, 2'd0, 8'($urandom), 1'b1, 10'h000, p);
        step(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 10'h100, p);
        step(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, 10'h3FF, p);

        // Blanking in between restarts the data sequence identically
        for (int i = 0; i < 16; i++) seq[i] = 8'($urandom);
        step(1'b0, 1'b1, 2'd0, 8'h81, 1'b0, 10'h000, p);
        step(1'b0, 1'b0, 2'd1, 8'h00, 1'b0, 10'h000, p);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 2'd0, seq[i], 1'b0, 10'h000, p);
            first_run[i] = p;
        end
        step(1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 10'h154, p);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 2'd0, seq[i], 1'b1, first_run[i], p);
        step(1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 10'h354, p);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
